rv32_fetch: RTL
===============

Name: rv32_fetch

Overview:
- Instruction-fetch stage: owns the fetch PC, issues reads on the instruction memory bus, and presents {instr, pc, predicted_taken} to decode.
- Consumes the execute-stage redirect, i.e. the branch unit's mispredict flag and the corrected PC from the branch PC mux.
- Generates the predicted_taken bit that travels down the pipe to the branch unit.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_in  in  1  decode cannot accept; hold outputs
flush_in  in  1  mispredict redirect from execute
flush_pc_in  in  32  corrected PC, valid when flush_in=1
instr_read_out  out  1  memory read request
instr_address_out  out  32  read address, bits [1:0] always 0
instr_ready_in  in  1  memory completes read this cycle
instr_read_value_in  in  32  read data, valid when instr_ready_in=1
valid_out  out  1  instr_out/pc_out hold a live instruction
instr_out  out  32  fetched instruction
pc_out  out  32  address of instr_out
predicted_taken_out  out  1  fetch predicted this instruction taken

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_VECTOR; state = REQ; skid buffer empty.
  - valid_out=0, instr_out=32'h0000_0013 (NOP), pc_out=0, predicted_taken_out=0.
  - instr_read_out=0 in the reset cycle.
- Bus rule: once instr_read_out=1, instr_read_out and instr_address_out stay constant until the cycle instr_ready_in=1. Data is sampled in that same cycle. At most one read is outstanding.
- Output register:
  - Loaded when a response arrives and (stall_in=0 or valid_out=0).
  - Holds all outputs unchanged while stall_in=1 and valid_out=1.
  - valid_out drops to 0 after a consume cycle (stall_in=0) with no new response.
- Skid buffer (1 entry): captures a response that arrives while the output register is held.
  - While the buffer is full, no new read is started.
  - The first cycle stall_in=0, the buffer moves to the output register.
- States:
  - REQ: instr_read_out=1 unless (buffer full) or (a read would be new and stall_in=1 with valid_out=1). An already-asserted read is never withdrawn. On instr_ready_in=1: capture data, fetch_pc <= next_pc.
  - DROP: entered on flush_in=1 while a read is asserted and instr_ready_in=0. Holds the old address until instr_ready_in=1, discards the data, then returns to REQ at the redirected PC.
- next_pc = fetch_pc+4, or the predicted target (see Optional Feature). Arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Flush: highest priority, overrides stall_in and the skid buffer. Next cycle:
  - valid_out=0 and buffer empty.
  - fetch_pc = {flush_pc_in[31:2],2'b00}.
  - Any response arriving in the flush cycle is discarded.
  - Flush during DROP updates the redirect target only.
- Reset mid-read: outstanding read is abandoned; bus returns to idle. The memory tolerates this.
- Latency: redirect to first new instr_read_out = 1 cycle (more if in DROP). Response to valid_out = 1 cycle.

Optional Feature:
Macro: RV32_STATIC_PREDICT_EN
- Defined — static prediction on each captured instruction:
  - JAL (opcode 1101111): predicted taken, target = pc + J-imm.
  - Conditional branch (1100011) with imm[12]=1 (backward): predicted taken, target = pc + B-imm.
  - The target becomes next_pc; predicted_taken_out=1 for that instruction.
  - JALR and forward branches: not taken.
- Not defined: next_pc = fetch_pc+4 always; predicted_taken_out tied to 0.

Decomposition:
- Shared package rv32_fetch_pkg:
  - fetch state enum {REQ, DROP}.
  - NOP constant 32'h0000_0013.
  - Opcode constants for JAL and BRANCH.
- Sub-module rv32_fetch_predictor: combinational, (instr, pc) -> (taken, target). Instantiated only under RV32_STATIC_PREDICT_EN.

Test Plan:
1. Reset with RESET_VECTOR=32'h100, memory always ready → addresses 0x100, 0x104, 0x108 on consecutive cycles; valid_out=1 from cycle 2 with pc_out=0x100.
2. stall_in=1 for 3 cycles while a response arrives → output holds the old instruction, skid buffer holds the new one, no read issued; on release the buffered instruction appears, followed by address+4.
3. flush_in=1 with flush_pc_in=0x2002 while read to 0x40 pending (ready asserted 2 cycles later) → address stays 0x40 until ready, data discarded, next read to 0x2000, valid_out=0 until 0x2000 returns.
4. flush_in and instr_ready_in in the same cycle → response discarded; next read at the redirect PC the following cycle.
5. With RV32_STATIC_PREDICT_EN: fetch at 0x200 returns beq with B-imm -8 → predicted_taken_out=1, next address 0x1F8. A forward beq → 0x204, predicted_taken_out=0.
6. Without the macro, fetch at 0xFFFF_FFFC → next address 0x0000_0000; predicted_taken_out=0 throughout.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the rv32 instruction-fetch stage.
package rv32_fetch_pkg;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    DROP = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/rv32_fetch_predictor.sv
// Static predictor: JAL and backward conditional branches are taken; purely combinational.
// No state, no backpressure; target is meaningful only when taken_o=1.
module rv32_fetch_predictor
  import rv32_fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] j_imm;
  logic [31:0] b_imm;

  always_comb begin
    j_imm    = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    b_imm    = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    taken_o  = 1'b0;
    target_o = pc_i + 32'd4;
    if (instr_i[6:0] == OPC_JAL) begin
      taken_o  = 1'b1;
      target_o = pc_i + j_imm;
    end else if (instr_i[6:0] == OPC_BRANCH && instr_i[31]) begin
      taken_o  = 1'b1;
      target_o = pc_i + b_imm;
    end
  end

endmodule

// File: rtl/rv32_fetch.sv
// Fetch stage: one outstanding read, 1-cycle response-to-valid, 1-entry skid under decode stall.
// Static prediction is built only with RV32_STATIC_PREDICT_EN defined; otherwise next_pc = pc+4.
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        instr_read_out,
  output logic [31:0] instr_address_out,
  input  logic        instr_ready_in,
  input  logic [31:0] instr_read_value_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        predicted_taken_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         read_q, read_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         pt_q, pt_d;
  logic         skid_vld_q, skid_vld_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic         skid_pt_q, skid_pt_d;

  logic         pred_taken;
  logic [31:0]  next_pc;
  logic         rsp;
  logic         pending;

`ifdef RV32_STATIC_PREDICT_EN
  logic [31:0] pred_target;

  rv32_fetch_predictor u_pred (
    .instr_i  (instr_read_value_in),
    .pc_i     (fetch_pc_q),
    .taken_o  (pred_taken),
    .target_o (pred_target)
  );

  assign next_pc = pred_taken ? pred_target : fetch_pc_q + 32'd4;
`else
  assign pred_taken = 1'b0;
  assign next_pc    = fetch_pc_q + 32'd4;
`endif

  // The request is registered so a read decided last cycle can complete during a new stall.
  assign instr_read_out    = read_q & ~reset;
  assign instr_address_out = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign rsp               = read_q & instr_ready_in;
  assign pending           = read_q & ~instr_ready_in;

  assign valid_out           = valid_q;
  assign instr_out           = instr_q;
  assign pc_out              = pc_q;
  assign predicted_taken_out = pt_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_addr_d  = instr_address_out;
    read_d       = read_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pt_d         = pt_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pt_d    = skid_pt_q;

    if (flush_in) begin
      valid_d    = 1'b0;
      skid_vld_d = 1'b0;
      fetch_pc_d = {flush_pc_in[31:2], 2'b00};
      read_d     = 1'b1;
      state_d    = pending ? DROP : REQ;
    end else if (state_q == DROP) begin
      if (!stall_in) valid_d = 1'b0;
      if (instr_ready_in) state_d = REQ;
    end else begin
      if (skid_vld_q) begin
        if (!stall_in) begin
          valid_d    = 1'b1;
          instr_d    = skid_instr_q;
          pc_d       = skid_pc_q;
          pt_d       = skid_pt_q;
          skid_vld_d = 1'b0;
        end
      end else if (rsp) begin
        fetch_pc_d = {next_pc[31:2], 2'b00};
        if (!stall_in || !valid_q) begin
          valid_d = 1'b1;
          instr_d = instr_read_value_in;
          pc_d    = fetch_pc_q;
          pt_d    = pred_taken;
        end else begin
          skid_vld_d   = 1'b1;
          skid_instr_d = instr_read_value_in;
          skid_pc_d    = fetch_pc_q;
          skid_pt_d    = pred_taken;
        end
      end else if (!stall_in) begin
        valid_d = 1'b0;
      end
      // An asserted read is held to completion; a new one waits for room downstream.
      if (!pending) read_d = !skid_vld_d && !(stall_in && valid_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      fetch_pc_q   <= {RESET_VECTOR[31:2], 2'b00};
      drop_addr_q  <= 32'h0;
      read_q       <= 1'b1;
      valid_q      <= 1'b0;
      instr_q      <= NOP;
      pc_q         <= 32'h0;
      pt_q         <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= 32'h0;
      skid_pt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_addr_q  <= drop_addr_d;
      read_q       <= read_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pt_q         <= pt_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pt_q    <= skid_pt_d;
    end
  end

endmodule
